// File: rtl/vpp_sweep_seq.sv
// vpp_sweep_seq: steps the DDS frequency word over n_points, settles, captures Vpp per point into a readable buffer
module vpp_sweep_seq #(
  parameter int KW_W  = 32,
  parameter int VPP_W = 12,
  parameter int IDX_W = 8,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [KW_W-1:0]  kw_start,
  input  logic [KW_W-1:0]  kw_step,
  input  logic [IDX_W-1:0] n_points,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic [VPP_W-1:0] vpp_in,
  input  logic             vpp_found_in,
  output logic [KW_W-1:0]  kw_out,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [IDX_W-1:0] pts_done,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [VPP_W-1:0] rd_data
);
  typedef enum logic [2:0] {IDLE, SETTLE, WAIT_VPP, STORE, DONE} state_t;
  state_t state_q, state_d;
  logic [KW_W-1:0] kw_q, kw_d;
  logic busy_q, busy_d, done_q, done_d, te_q, te_d;
  logic [IDX_W-1:0] idx_q, idx_d, pts_q, pts_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, tcnt_q, tcnt_d;
  logic [2:0] sync_q;
  logic found_ev, we;
  logic [VPP_W-1:0] wd, rd_q;
  logic [VPP_W-1:0] mem [2**IDX_W];
  // sync_q[1:0] is the synchronizer; sync_q[2] is the previous synced value for edge detect
  assign found_ev = sync_q[1] & ~sync_q[2];
  always_comb begin
    state_d = state_q;
    kw_d = kw_q;
    busy_d = busy_q;
    done_d = 1'b0;
    te_d = te_q;
    idx_d = idx_q;
    pts_d = pts_q;
    scnt_d = scnt_q;
    tcnt_d = tcnt_q;
    we = 1'b0;
    wd = vpp_in;
    if (abort) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (n_points != '0) begin
            kw_d = kw_start;
            idx_d = '0;
            pts_d = '0;
            te_d = 1'b0;
            busy_d = 1'b1;
            scnt_d = settle_cycles;
            state_d = SETTLE;
          end else done_d = 1'b1;
        end
        SETTLE: if (scnt_q == '0) begin
          tcnt_d = timeout_cycles;
          state_d = WAIT_VPP;
        end else scnt_d = scnt_q - 1'b1;
        WAIT_VPP: if (found_ev) begin
          we = 1'b1;
          state_d = STORE;
        end else if (tcnt_q == '0) begin
          we = 1'b1;
          wd = '1;
          te_d = 1'b1;
          state_d = STORE;
        end else tcnt_d = tcnt_q - 1'b1;
        STORE: begin
          pts_d = idx_q + 1'b1;
          if (idx_q == n_points - 1'b1) begin
            done_d = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            kw_d = kw_q + kw_step;
            scnt_d = settle_cycles;
            state_d = SETTLE;
          end
        end
        DONE: begin
          busy_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kw_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      te_q <= 1'b0;
      idx_q <= '0;
      pts_q <= '0;
      scnt_q <= '0;
      tcnt_q <= '0;
      sync_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      kw_q <= kw_d;
      busy_q <= busy_d;
      done_q <= done_d;
      te_q <= te_d;
      idx_q <= idx_d;
      pts_q <= pts_d;
      scnt_q <= scnt_d;
      tcnt_q <= tcnt_d;
      sync_q <= {sync_q[1:0], vpp_found_in};
      rd_q <= mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[idx_q] <= wd;
  end
  assign kw_out = kw_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout_err = te_q;
  assign pts_done = pts_q;
  assign rd_data = rd_q;
endmodule
